pump_rotator: RTL and testbench
===============================

Name: pump_rotator

Overview:
- N-pump lead/lag rotation controller; successor to the two-pump alternator.
- On each demand cycle it starts the next healthy pump in round-robin order after the last one used, and enforces a minimum run time.
- Fails over with break-before-make when the running pump faults.
- Sits between the level/demand logic and the pump contactor drivers.

Parameters:
N_PUMPS, 4, number of pumps (2..16)
MIN_RUN, 8, minimum clock cycles a started pump stays on absent a fault (>=1)
IDX_W, $clog2(N_PUMPS), width of pump index

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
demand  in  1  level; 1 = water required
pump_fault  in  N_PUMPS  per-pump fault/unavailable flag, level
pump_en  out  N_PUMPS  one-hot (or zero) pump drive, registered
active_idx  out  IDX_W  index of running pump; valid when running=1
running  out  1  a pump is driven
all_faulted  out  1  every pump faulted, registered
fault_event  out  1  one-cycle pulse: running pump dropped due to fault

Behaviour:
- Reset (sync, active-high, highest priority, also mid-operation):
  - state=IDLE; pump_en=0; running=0; active_idx=0; fault_event=0; all_faulted=0.
  - last_idx=N_PUMPS-1, so pump 0 is the first one selected.
- Selection function next_healthy(last_idx, pump_fault):
  - first index i in the cyclic order last_idx+1, last_idx+2, ... , last_idx (wraps mod N_PUMPS) with pump_fault[i]=0.
  - none_ok when all are faulted.
  - last_idx itself is the last candidate, so a single healthy pump is always reusable.
- all_faulted is registered &pump_fault, updated every cycle.
- States:
  - IDLE:
    - pump_en=0.
    - demand=1 and !none_ok: go to RUN; cur=next_healthy; counter=MIN_RUN-1.
    - Edge at which demand=1 is sampled → pump_en valid after that same edge (latency 1 clk).
  - RUN:
    - pump_en=onehot(cur); running=1; active_idx=cur.
    - Counter decrements each cycle and saturates at 0.
    - Priority 1: pump_fault[cur]=1 → next edge: pump_en=0, fault_event=1, last_idx=cur, go to SWITCH (min-run is ignored).
    - Priority 2: demand=0 and counter==0 → pump_en=0, last_idx=cur, go to IDLE.
    - demand=0 with counter>0: keep running until the counter reaches 0.
  - SWITCH (exactly 1 dead cycle, break-before-make):
    - pump_en=0.
    - Next edge: demand=1 and !none_ok → RUN with next_healthy, counter reloaded.
    - Otherwise → IDLE.
- Rotation: last_idx updates only on leaving RUN, so the successive demand cycles of a fault-free system use 0,1,2,...,N-1,0.
- Faulted pump skipped: a pump that faults while idle is passed over; it rejoins the rotation when its fault clears.
- Demand with all pumps faulted: stays IDLE, all_faulted=1. Start occurs the cycle after any fault clears while demand=1.
- Invariant: pump_en is always $onehot0; at most one pump is on in any cycle.
- Fault and demand drop on the same cycle: the fault path wins (fault_event pulses), and SWITCH then goes to IDLE.

Decomposition:
- Shared package pump_pkg:
  - state enum IDLE/RUN/SWITCH (2-bit encoding).
  - onehot(idx) function.
  - next_healthy function, parametrised by N_PUMPS.
- One natural sub-module: pump_rr_sel, purely combinational (last_idx, pump_fault → sel_idx, none_ok), reusable by other rotation blocks.
- The counter and FSM stay in pump_rotator.

Test Plan:
- All tests use N_PUMPS=4, MIN_RUN=4.
- Reset then demand=1 for 6 cycles then 0, repeated 5 times, no faults → pump_en sequence 0001,0010,0100,1000,0001; each burst on 6 cycles; 0 between bursts.
- demand pulse of 1 cycle → pump_en=0001 for exactly 4 cycles (minimum run), then 0.
- Pump 1 running, pump_fault=0010 asserted → next cycle pump_en=0000 and fault_event=1; following cycle pump_en=0100; pump 1 skipped on later rotations until its fault clears.
- pump_fault=1111, demand=1 → pump_en=0, all_faulted=1; clear pump_fault[3] → pump_en=1000 within 2 cycles.
- Only pump 2 healthy (pump_fault=1011), three demand bursts → pump 2 used every time.
- reset asserted mid-RUN (pump 2 on) → next cycle all outputs 0; subsequent demand starts pump 0.

Source files
------------

// File: rtl/pump_pkg.sv
// Shared types and helpers for pump rotation blocks: FSM state encoding,
// one-hot decode and the round-robin healthy-pump search.
package pump_pkg;

  // Widest configuration supported by the helpers below.
  localparam int MAX_PUMPS = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } pump_state_t;

  typedef struct packed {
    logic                 none_ok;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // Decode a pump index into a one-hot drive word (callers truncate to N_PUMPS).
  function automatic logic [MAX_PUMPS-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_PUMPS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First healthy pump after last_idx in cyclic order; last_idx itself is the
  // final candidate so a lone healthy pump keeps being reused. The scan runs
  // from the farthest candidate to the nearest so the nearest hit wins without
  // needing an early exit.
  function automatic rr_pick_t next_healthy(
    input logic [MAX_IDX_W-1:0] last_idx,
    input logic [MAX_PUMPS-1:0] fault,
    input int                   n
  );
    rr_pick_t             pick;
    int                   cand;
    logic [MAX_IDX_W-1:0] cand_idx;
    pick.none_ok = 1'b1;
    pick.idx     = '0;
    for (int k = MAX_PUMPS; k >= 1; k--) begin
      if (k <= n) begin
        cand     = (int'(last_idx) + k) % n;
        cand_idx = MAX_IDX_W'(cand);
        if (!fault[cand_idx]) begin
          pick.none_ok = 1'b0;
          pick.idx     = cand_idx;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pump_rotator_if.sv
// Demand/fault inputs and pump drive/status outputs of the rotation controller.
interface pump_rotator_if #(
  parameter int N_PUMPS = 4,
  parameter int IDX_W   = $clog2(N_PUMPS)
);
  logic               demand;
  logic [N_PUMPS-1:0] pump_fault;
  logic [N_PUMPS-1:0] pump_en;
  logic [IDX_W-1:0]   active_idx;
  logic               running;
  logic               all_faulted;
  logic               fault_event;

  // Level/demand logic side.
  modport master (
    output demand, pump_fault,
    input  pump_en, active_idx, running, all_faulted, fault_event
  );

  // Rotation controller side.
  modport slave (
    input  demand, pump_fault,
    output pump_en, active_idx, running, all_faulted, fault_event
  );
endinterface

// File: rtl/pump_rr_sel.sv
// Combinational round-robin selector: next healthy pump after i_last_idx.
module pump_rr_sel
  import pump_pkg::*;
#(
  parameter int N_PUMPS = 4,
  parameter int IDX_W   = $clog2(N_PUMPS)
) (
  input  logic [IDX_W-1:0]   i_last_idx,
  input  logic [N_PUMPS-1:0] i_pump_fault,
  output logic [IDX_W-1:0]   o_sel_idx,
  output logic               o_none_ok
);

  rr_pick_t w_pick;

  // Widen to the helper's fixed width; pumps beyond N_PUMPS are never visited.
  always_comb begin
    w_pick = next_healthy(MAX_IDX_W'(i_last_idx), MAX_PUMPS'(i_pump_fault), N_PUMPS);
  end

  assign o_sel_idx = IDX_W'(w_pick.idx);
  assign o_none_ok = w_pick.none_ok;

endmodule

// File: rtl/pump_rotator.sv
// N-pump lead/lag rotation controller: round-robin start on demand, minimum
// run time, break-before-make failover when the running pump faults.
module pump_rotator
  import pump_pkg::*;
#(
  parameter int N_PUMPS = 4,
  parameter int MIN_RUN = 8,
  parameter int IDX_W   = $clog2(N_PUMPS)
) (
  input  logic          clk,
  input  logic          reset,
  pump_rotator_if.slave bus
);

  // Counter only has to hold MIN_RUN-1.
  localparam int CNT_W = (MIN_RUN > 1) ? $clog2(MIN_RUN) : 1;

  pump_state_t        r_state, w_state_next;
  logic [IDX_W-1:0]   r_cur, w_cur_next;
  logic [IDX_W-1:0]   r_last, w_last_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [N_PUMPS-1:0] r_pump_en, w_pump_en_next;
  logic               r_fault_event, w_fault_event_next;
  logic               r_all_faulted;

  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_none_ok;
  logic               w_cur_faulted;

  // Rotation always resumes from the pump that last left RUN.
  pump_rr_sel #(
    .N_PUMPS (N_PUMPS),
    .IDX_W   (IDX_W)
  ) u_sel (
    .i_last_idx   (r_last),
    .i_pump_fault (bus.pump_fault),
    .o_sel_idx    (w_sel_idx),
    .o_none_ok    (w_none_ok)
  );

  assign w_cur_faulted = bus.pump_fault[r_cur];

  // Next-state logic: fault beats min-run, which beats demand drop.
  always_comb begin
    w_state_next       = r_state;
    w_cur_next         = r_cur;
    w_last_next        = r_last;
    w_cnt_next         = r_cnt;
    w_fault_event_next = 1'b0;
    case (r_state)
      ST_IDLE, ST_SWITCH: begin
        // SWITCH is the single dead cycle after a fault; it then starts like IDLE.
        if (bus.demand && !w_none_ok) begin
          w_state_next = ST_RUN;
          w_cur_next   = w_sel_idx;
          w_cnt_next   = CNT_W'(MIN_RUN - 1);
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_cur_faulted) begin
          w_state_next       = ST_SWITCH;
          w_fault_event_next = 1'b1;
          w_last_next        = r_cur;
        end else if (!bus.demand && (r_cnt == '0)) begin
          w_state_next = ST_IDLE;
          w_last_next  = r_cur;
        end else if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    w_pump_en_next = (w_state_next == ST_RUN)
                   ? N_PUMPS'(onehot(MAX_IDX_W'(w_cur_next)))
                   : '0;
  end

  // State and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cur         <= '0;
      r_last        <= IDX_W'(N_PUMPS - 1);
      r_cnt         <= '0;
      r_pump_en     <= '0;
      r_fault_event <= 1'b0;
      r_all_faulted <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cur         <= w_cur_next;
      r_last        <= w_last_next;
      r_cnt         <= w_cnt_next;
      r_pump_en     <= w_pump_en_next;
      r_fault_event <= w_fault_event_next;
      r_all_faulted <= &bus.pump_fault;
    end
  end

  assign bus.pump_en     = r_pump_en;
  assign bus.active_idx  = r_cur;
  assign bus.running     = (r_state == ST_RUN);
  assign bus.all_faulted = r_all_faulted;
  assign bus.fault_event = r_fault_event;

endmodule

// File: tb/tb_pump_rotator.sv
// Self-checking bench for pump_rotator (N_PUMPS=4, MIN_RUN=4).
module tb_pump_rotator;

  localparam int N  = 4;
  localparam int MR = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  // Reference model: is a pump on, which one, who ran last, cycles it has been on.
  bit           m_on;
  int           m_cur;
  int           m_last;
  int           m_age;
  bit           m_fev;
  bit           m_allf;
  logic [N-1:0] m_en;

  pump_rotator_if #(.N_PUMPS(N)) bus ();

  pump_rotator #(.N_PUMPS(N), .MIN_RUN(MR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int pick_next(int last, logic [N-1:0] f);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (f[i] == 1'b0) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    int p;
    if (reset) begin
      m_on = 0; m_cur = 0; m_last = N - 1; m_age = 0; m_fev = 0; m_allf = 0;
    end else begin
      m_allf = &bus.pump_fault;
      m_fev  = 0;
      if (m_on) begin
        if (bus.pump_fault[m_cur]) begin
          m_on = 0; m_fev = 1; m_last = m_cur;
        end else if (!bus.demand && m_age >= MR) begin
          m_on = 0; m_last = m_cur;
        end else begin
          m_age++;
        end
      end else if (bus.demand) begin
        p = pick_next(m_last, bus.pump_fault);
        if (p >= 0) begin
          m_on = 1; m_cur = p; m_age = 1;
        end
      end
    end
    m_en = m_on ? (N'(1) << m_cur) : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_burst(input int len, output logic [N-1:0] first_en);
    bus.demand = 1'b1;
    tick();
    first_en = bus.pump_en;
    for (int c = 1; c < len; c++) tick();
    bus.demand = 1'b0;
    for (int c = 0; c < MR + 2 && bus.running; c++) tick();
    tick();
    $display("burst len=%0d first_en=%b fault=%b", len, first_en, bus.pump_fault);
  endtask

  task automatic test_reset();
    bus.demand     = 1'b0;
    bus.pump_fault = '1;
    reset          = 1'b1;
    tick();
    tick();
    checks++; if (bus.pump_en !== '0) begin errors++; $display("FAIL reset_en got=%b want=0000", bus.pump_en); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b want=0", bus.running); end
    checks++; if (bus.active_idx !== '0) begin errors++; $display("FAIL reset_idx got=%0d want=0", bus.active_idx); end
    checks++; if (bus.fault_event !== 1'b0) begin errors++; $display("FAIL reset_fev got=%b want=0", bus.fault_event); end
    checks++; if (bus.all_faulted !== 1'b0) begin errors++; $display("FAIL reset_allf got=%b want=0", bus.all_faulted); end
    bus.pump_fault = '0;
    tick();
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_rotation();
    logic [N-1:0] first_en;
    logic [N-1:0] want;
    int           on_cnt;
    do_reset();
    for (int b = 0; b < 5; b++) begin
      bus.demand = 1'b1;
      on_cnt     = 0;
      first_en   = '0;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (c == 0) first_en = bus.pump_en;
        if (bus.pump_en != '0) on_cnt++;
        checks++; if (bus.pump_en !== m_en) begin errors++; $display("FAIL rot_model b=%0d c=%0d got=%b want=%b", b, c, bus.pump_en, m_en); end
      end
      want = N'(1) << (b % N);
      checks++; if (first_en !== want) begin errors++; $display("FAIL rot_first b=%0d got=%b want=%b", b, first_en, want); end
      checks++; if (on_cnt != 6) begin errors++; $display("FAIL rot_len b=%0d got=%0d want=6", b, on_cnt); end
      bus.demand = 1'b0;
      for (int c = 0; c < 2; c++) begin
        tick();
        checks++; if (bus.pump_en !== '0) begin errors++; $display("FAIL rot_gap b=%0d got=%b want=0000", b, bus.pump_en); end
      end
      $display("rotation burst %0d first_en=%b on=%0d", b, first_en, on_cnt);
    end
  endtask

  task automatic test_min_run();
    logic [N-1:0] want;
    do_reset();
    bus.demand = 1'b1;
    tick();
    checks++; if (bus.pump_en !== 4'b0001) begin errors++; $display("FAIL minrun_start got=%b want=0001", bus.pump_en); end
    bus.demand = 1'b0;
    for (int t = 1; t < 8; t++) begin
      tick();
      want = (t < MR) ? 4'b0001 : 4'b0000;
      checks++; if (bus.pump_en !== want) begin errors++; $display("FAIL minrun t=%0d got=%b want=%b", t, bus.pump_en, want); end
    end
    $display("test_min_run done");
  endtask

  task automatic test_fault_failover();
    logic [N-1:0] first_en;
    logic [N-1:0] want;
    int           seq [6] = '{3, 0, 2, 3, 0, 1};
    do_reset();
    run_burst(6, first_en);
    checks++; if (first_en !== 4'b0001) begin errors++; $display("FAIL fo_pre got=%b want=0001", first_en); end
    bus.demand = 1'b1;
    tick();
    checks++; if (bus.pump_en !== 4'b0010) begin errors++; $display("FAIL fo_run1 got=%b want=0010", bus.pump_en); end
    tick();
    tick();
    bus.pump_fault = 4'b0010;
    tick();
    checks++; if (bus.pump_en !== 4'b0000) begin errors++; $display("FAIL fo_break got=%b want=0000", bus.pump_en); end
    checks++; if (bus.fault_event !== 1'b1) begin errors++; $display("FAIL fo_fev got=%b want=1", bus.fault_event); end
    tick();
    checks++; if (bus.pump_en !== 4'b0100) begin errors++; $display("FAIL fo_make got=%b want=0100", bus.pump_en); end
    checks++; if (bus.fault_event !== 1'b0) begin errors++; $display("FAIL fo_fev_pulse got=%b want=0", bus.fault_event); end
    checks++; if (bus.active_idx !== 2'd2) begin errors++; $display("FAIL fo_idx got=%0d want=2", bus.active_idx); end
    bus.demand = 1'b0;
    for (int c = 0; c < MR + 2 && bus.running; c++) tick();
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL fo_stop got=%b want=0", bus.running); end
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) bus.pump_fault = '0;
      run_burst(6, first_en);
      want = N'(1) << seq[i];
      checks++; if (first_en !== want) begin errors++; $display("FAIL fo_seq i=%0d got=%b want=%b", i, first_en, want); end
      checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL fo_seq_stop i=%0d got=%b want=0", i, bus.running); end
    end
  endtask

  task automatic test_all_faulted();
    bit found;
    do_reset();
    bus.pump_fault = 4'b1111;
    bus.demand     = 1'b1;
    repeat (3) tick();
    checks++; if (bus.pump_en !== 4'b0000) begin errors++; $display("FAIL allf_en got=%b want=0000", bus.pump_en); end
    checks++; if (bus.all_faulted !== 1'b1) begin errors++; $display("FAIL allf_flag got=%b want=1", bus.all_faulted); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL allf_running got=%b want=0", bus.running); end
    bus.pump_fault = 4'b0111;
    found = 0;
    for (int t = 0; t < 2 && !found; t++) begin
      tick();
      if (bus.pump_en === 4'b1000) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL allf_recover got=%b want=1000", bus.pump_en); end
    checks++; if (bus.all_faulted !== 1'b0) begin errors++; $display("FAIL allf_clear got=%b want=0", bus.all_faulted); end
    bus.demand = 1'b0;
    for (int c = 0; c < MR + 2 && bus.running; c++) tick();
    bus.pump_fault = '0;
    tick();
    $display("test_all_faulted done");
  endtask

  task automatic test_single_healthy();
    logic [N-1:0] first_en;
    do_reset();
    bus.pump_fault = 4'b1011;
    for (int b = 0; b < 3; b++) begin
      run_burst(6, first_en);
      checks++; if (first_en !== 4'b0100) begin errors++; $display("FAIL single b=%0d got=%b want=0100", b, first_en); end
    end
    bus.pump_fault = '0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic [N-1:0] first_en;
    do_reset();
    run_burst(6, first_en);
    run_burst(6, first_en);
    bus.demand = 1'b1;
    tick();
    checks++; if (bus.pump_en !== 4'b0100) begin errors++; $display("FAIL rmid_run got=%b want=0100", bus.pump_en); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if (bus.pump_en !== '0) begin errors++; $display("FAIL rmid_en got=%b want=0000", bus.pump_en); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL rmid_running got=%b want=0", bus.running); end
    checks++; if (bus.active_idx !== '0) begin errors++; $display("FAIL rmid_idx got=%0d want=0", bus.active_idx); end
    checks++; if (bus.fault_event !== 1'b0) begin errors++; $display("FAIL rmid_fev got=%b want=0", bus.fault_event); end
    reset = 1'b0;
    tick();
    checks++; if (bus.pump_en !== 4'b0001) begin errors++; $display("FAIL rmid_restart got=%b want=0001", bus.pump_en); end
    bus.demand = 1'b0;
    for (int c = 0; c < MR + 2 && bus.running; c++) tick();
    $display("test_reset_mid_run done");
  endtask

  task automatic test_fault_and_drop();
    do_reset();
    bus.demand = 1'b1;
    repeat (6) tick();
    bus.demand     = 1'b0;
    bus.pump_fault = 4'b0001;
    tick();
    checks++; if (bus.pump_en !== '0) begin errors++; $display("FAIL fd_en got=%b want=0000", bus.pump_en); end
    checks++; if (bus.fault_event !== 1'b1) begin errors++; $display("FAIL fd_fev got=%b want=1", bus.fault_event); end
    bus.pump_fault = '0;
    tick();
    checks++; if (bus.pump_en !== '0) begin errors++; $display("FAIL fd_idle_en got=%b want=0000", bus.pump_en); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL fd_idle_running got=%b want=0", bus.running); end
    checks++; if (bus.fault_event !== 1'b0) begin errors++; $display("FAIL fd_fev_pulse got=%b want=0", bus.fault_event); end
    tick();
    checks++; if (bus.pump_en !== '0) begin errors++; $display("FAIL fd_stay got=%b want=0000", bus.pump_en); end
    $display("test_fault_and_drop done");
  endtask

  task automatic test_random();
    int b;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ($urandom_range(0, 7) == 0) bus.demand = ~bus.demand;
      if ($urandom_range(0, 14) == 0) begin
        b = $urandom_range(0, N - 1);
        bus.pump_fault[b] = ~bus.pump_fault[b];
      end
      reset = ($urandom_range(0, 149) == 0);
      tick();
      checks++; if (bus.pump_en !== m_en) begin errors++; $display("FAIL rnd_en cyc=%0d got=%b want=%b", cyc, bus.pump_en, m_en); end
      checks++; if (bus.running !== m_on) begin errors++; $display("FAIL rnd_running cyc=%0d got=%b want=%b", cyc, bus.running, m_on); end
      checks++; if (bus.fault_event !== m_fev) begin errors++; $display("FAIL rnd_fev cyc=%0d got=%b want=%b", cyc, bus.fault_event, m_fev); end
      checks++; if (bus.all_faulted !== m_allf) begin errors++; $display("FAIL rnd_allf cyc=%0d got=%b want=%b", cyc, bus.all_faulted, m_allf); end
      if (m_on) begin
        checks++; if (int'(bus.active_idx) != m_cur) begin errors++; $display("FAIL rnd_idx cyc=%0d got=%0d want=%0d", cyc, bus.active_idx, m_cur); end
      end
      checks++; if (!$onehot0(bus.pump_en)) begin errors++; $display("FAIL rnd_onehot cyc=%0d got=%b want=onehot0", cyc, bus.pump_en); end
    end
    reset          = 1'b0;
    bus.demand     = 1'b0;
    bus.pump_fault = '0;
    $display("test_random done");
  endtask

  initial begin
    reset          = 1'b1;
    bus.demand     = 1'b0;
    bus.pump_fault = '0;
    test_reset();
    test_rotation();
    test_min_run();
    test_fault_failover();
    test_all_faulted();
    test_single_healthy();
    test_reset_mid_run();
    test_fault_and_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
